// File: rtl/mc_pkg.sv
// mc_pkg: shared constants, encodings and enums for the multi-cycle MIPS control FSM.
// Holds the ALU operation codes, MIPS opcode/funct values, datapath select
// encodings, the FSM state enum and the instruction class enum.
package mc_pkg;

    localparam logic [3:0] ALU_ADDU = 4'b0000;
    localparam logic [3:0] ALU_SUBU = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1100;
    localparam logic [3:0] ALU_SRL  = 4'b1101;
    localparam logic [3:0] ALU_SLL  = 4'b1110;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam logic [1:0] A_PC = 2'd0, A_RS = 2'd1, A_SHAMT = 2'd2;
    localparam logic [1:0] B_RT = 2'd0, B_FOUR = 2'd1, B_SIMM = 2'd2, B_ZIMM = 2'd3;
    localparam logic [1:0] PC_ALU = 2'd0, PC_BR = 2'd1, PC_JMP = 2'd2, PC_RS = 2'd3;
    localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_R31 = 2'd2;
    localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_ILL
    } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction classifier for the multi-cycle control FSM.
// Ports: instr_i (IR contents) -> cls_o (instruction class), aluc_o (ALU op),
// a_sel_o/b_sel_o (EXEC operand selects), reg_dst_sel_o (destination register),
// is_store_o (sw), is_link_o (jal).
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0] instr_i,
    output iclass_t     cls_o,
    output logic [3:0]  aluc_o,
    output logic [1:0]  a_sel_o,
    output logic [1:0]  b_sel_o,
    output logic [1:0]  reg_dst_sel_o,
    output logic        is_store_o,
    output logic        is_link_o
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       unused_fields;

    assign op            = instr_i[31:26];
    assign fn            = instr_i[5:0];
    assign unused_fields = ^instr_i[25:6];
    assign is_store_o    = cls_o == C_STORE;
    assign is_link_o     = cls_o == C_JAL;

    always_comb begin
        cls_o         = C_ILL;
        aluc_o        = ALU_ADDU;
        a_sel_o       = A_RS;
        b_sel_o       = B_RT;
        reg_dst_sel_o = DST_RT;
        case (op)
            OP_RTYPE: begin
                cls_o         = C_ALU_R;
                reg_dst_sel_o = DST_RD;
                case (fn)
                    F_SLL:   begin aluc_o = ALU_SLL; a_sel_o = A_SHAMT; end
                    F_SRL:   begin aluc_o = ALU_SRL; a_sel_o = A_SHAMT; end
                    F_SRA:   begin aluc_o = ALU_SRA; a_sel_o = A_SHAMT; end
                    F_SLLV:  aluc_o = ALU_SLL;
                    F_SRLV:  aluc_o = ALU_SRL;
                    F_SRAV:  aluc_o = ALU_SRA;
                    F_JR:    cls_o  = C_JR;
                    F_ADD:   aluc_o = ALU_ADD;
                    F_ADDU:  aluc_o = ALU_ADDU;
                    F_SUB:   aluc_o = ALU_SUB;
                    F_SUBU:  aluc_o = ALU_SUBU;
                    F_AND:   aluc_o = ALU_AND;
                    F_OR:    aluc_o = ALU_OR;
                    F_XOR:   aluc_o = ALU_XOR;
                    F_NOR:   aluc_o = ALU_NOR;
                    F_SLT:   aluc_o = ALU_SLT;
                    F_SLTU:  aluc_o = ALU_SLTU;
                    default: cls_o  = C_ILL;
                endcase
            end
            OP_J:     cls_o = C_J;
            OP_JAL:   begin cls_o = C_JAL; reg_dst_sel_o = DST_R31; end
            OP_BEQ:   begin cls_o = C_BEQ; aluc_o = ALU_SUBU; end
            OP_BNE:   begin cls_o = C_BNE; aluc_o = ALU_SUBU; end
            OP_ADDI:  begin cls_o = C_ALU_I; aluc_o = ALU_ADD;  b_sel_o = B_SIMM; end
            OP_ADDIU: begin cls_o = C_ALU_I; aluc_o = ALU_ADDU; b_sel_o = B_SIMM; end
            OP_SLTI:  begin cls_o = C_ALU_I; aluc_o = ALU_SLT;  b_sel_o = B_SIMM; end
            OP_SLTIU: begin cls_o = C_ALU_I; aluc_o = ALU_SLTU; b_sel_o = B_SIMM; end
            OP_ANDI:  begin cls_o = C_ALU_I; aluc_o = ALU_AND;  b_sel_o = B_ZIMM; end
            OP_ORI:   begin cls_o = C_ALU_I; aluc_o = ALU_OR;   b_sel_o = B_ZIMM; end
            OP_XORI:  begin cls_o = C_ALU_I; aluc_o = ALU_XOR;  b_sel_o = B_ZIMM; end
            OP_LUI:   begin cls_o = C_ALU_I; aluc_o = ALU_LUI;  b_sel_o = B_ZIMM; end
            OP_LW:    begin cls_o = C_LOAD;  b_sel_o = B_SIMM; end
            OP_SW:    begin cls_o = C_STORE; b_sel_o = B_SIMM; end
            default:  cls_o = C_ILL;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Inputs: clk, rst (async, active high), instr (IR), zero/overflow (ALU flags),
// mem_ack (memory done). Outputs: mem_req/mem_we (memory port), ir_we/pc_we/
// reg_we (write enables), aluc and alu_a_sel/alu_b_sel (ALU control), pc_sel,
// reg_dst_sel, wb_sel (datapath muxes), illegal (pulse), exc (sticky trap), state.
// Build option: define MC_OVF_TRAP_EN to trap on signed overflow of add/sub/addi.
module mc_control
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        overflow,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic [3:0]  aluc,
    output logic [1:0]  alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [1:0]  pc_sel,
    output logic [1:0]  reg_dst_sel,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic        exc,
    output logic [2:0]  state
);

    state_t     state_q, state_d;
    logic       exc_q, exc_d;
    iclass_t    cls;
    logic [3:0] dec_aluc;
    logic [1:0] dec_a, dec_b, dec_dst;
    logic       is_store, is_link, ovf_trap;
    logic       unused_reset_pc;

    assign unused_reset_pc = ^RESET_PC;

    mc_decode u_decode (
        .instr_i       (instr),
        .cls_o         (cls),
        .aluc_o        (dec_aluc),
        .a_sel_o       (dec_a),
        .b_sel_o       (dec_b),
        .reg_dst_sel_o (dec_dst),
        .is_store_o    (is_store),
        .is_link_o     (is_link)
    );

`ifdef MC_OVF_TRAP_EN
    // Only add, sub and addi decode to the trapping ALU ops.
    assign ovf_trap = overflow && (dec_aluc == ALU_ADD || dec_aluc == ALU_SUB);
`else
    logic unused_overflow;
    assign unused_overflow = overflow;
    assign ovf_trap        = 1'b0;
`endif

    assign exc_d = exc_q | (state_q == S_EXEC && ovf_trap);
    assign exc   = exc_q;
    assign state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
        end
    end

    // Outputs are forced to their idle values while rst is high so nothing
    // reaches memory or the register file during reset.
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        reg_we      = 1'b0;
        aluc        = ALU_ADDU;
        alu_a_sel   = A_PC;
        alu_b_sel   = B_RT;
        pc_sel      = PC_ALU;
        reg_dst_sel = DST_RT;
        wb_sel      = WB_ALU;
        illegal     = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_b_sel = B_FOUR;
                    ir_we     = mem_ack;
                    pc_we     = mem_ack;
                    state_d   = mem_ack ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    pc_we       = cls inside {C_J, C_JAL, C_JR};
                    pc_sel      = cls == C_JR ? PC_RS : PC_JMP;
                    reg_we      = is_link;
                    reg_dst_sel = dec_dst;
                    wb_sel      = is_link ? WB_PC : WB_ALU;
                    illegal     = cls == C_ILL;
                    state_d     = cls inside {C_J, C_JAL, C_JR, C_ILL} ? S_FETCH : S_EXEC;
                end
                S_EXEC: begin
                    aluc      = dec_aluc;
                    alu_a_sel = dec_a;
                    alu_b_sel = dec_b;
                    pc_we     = (cls == C_BEQ && zero) || (cls == C_BNE && !zero);
                    pc_sel    = PC_BR;
                    state_d   = cls inside {C_BEQ, C_BNE}    ? S_FETCH :
                                cls inside {C_LOAD, C_STORE} ? S_MEM   :
                                ovf_trap                     ? S_TRAP  : S_WB;
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = is_store;
                    state_d = !mem_ack ? S_MEM : is_store ? S_FETCH : S_WB;
                end
                S_WB: begin
                    reg_we      = 1'b1;
                    reg_dst_sel = dec_dst;
                    wb_sel      = cls == C_LOAD ? WB_MEM : WB_ALU;
                    state_d     = S_FETCH;
                end
                S_TRAP:  state_d = S_TRAP;
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized scoreboard bench for mc_control against a per-instruction cycle model.
module tb_mc_control;
`ifdef MC_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1, zero = 1'b0, overflow = 1'b0, mem_ack = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        mem_req, mem_we, ir_we, pc_we, reg_we, illegal, exc;
  logic [3:0]  aluc;
  logic [1:0]  alu_a_sel, alu_b_sel, pc_sel, reg_dst_sel, wb_sel;
  logic [2:0]  state;

  always #5 clk = ~clk;

  mc_control dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .overflow(overflow),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
    .pc_we(pc_we), .reg_we(reg_we), .aluc(aluc), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .pc_sel(pc_sel), .reg_dst_sel(reg_dst_sel),
    .wb_sel(wb_sel), .illegal(illegal), .exc(exc), .state(state)
  );

  typedef enum {K_R, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_ILL} kind_t;

  typedef struct {
    string      nm;
    kind_t      k;
    logic [5:0] op, fn;
    logic [3:0] aluc;
    logic [1:0] a, b;
    bit         trp;
  } ent_t;

  typedef struct packed {
    logic        rst, ack, z, ov, full, alu;
    logic [31:0] ins;
    logic [2:0]  st;
    logic        mreq, mwe, irwe, pcwe, regwe, ill, exc;
    logic [3:0]  aluc;
    logic [1:0]  a, b, pcs, dst, wb;
  } cyc_t;

  ent_t  tab[$];
  cyc_t  expq[$];
  string tagq[$];
  string cur_name = "reset";
  int    nchk = 0, nerr = 0;

  task automatic ent(input string nm, input kind_t k, input logic [5:0] op, input logic [5:0] fn,
                     input logic [3:0] al, input logic [1:0] a, input logic [1:0] b, input bit trp);
    ent_t e;
    e.nm = nm; e.k = k; e.op = op; e.fn = fn; e.aluc = al; e.a = a; e.b = b; e.trp = trp;
    tab.push_back(e);
  endtask

  function automatic int idx(input string nm);
    foreach (tab[i]) if (tab[i].nm == nm) return i;
    return 0;
  endfunction

  task automatic step(input cyc_t c);
    @(posedge clk);
    #1;
    rst = c.rst; mem_ack = c.ack; zero = c.z; overflow = c.ov; instr = c.ins;
    expq.push_back(c);
    tagq.push_back(cur_name);
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      cyc_t  e;
      string t;
      bit    ok;
      e  = expq.pop_front();
      t  = tagq.pop_front();
      ok = state === e.st && mem_req === e.mreq && ir_we === e.irwe && pc_we === e.pcwe &&
           reg_we === e.regwe && illegal === e.ill && exc === e.exc;
      if (e.mreq || e.full) ok = ok && mem_we === e.mwe;
      if (e.pcwe || e.full) ok = ok && pc_sel === e.pcs;
      if (e.regwe || e.full) ok = ok && reg_dst_sel === e.dst && wb_sel === e.wb;
      if (e.alu || e.full) ok = ok && aluc === e.aluc && alu_a_sel === e.a && alu_b_sel === e.b;
      nchk++;
      if (!ok) begin
        nerr++;
        $display("FAIL %s @%0t: got st=%0d req=%b we=%b ir=%b pc=%b/%0d reg=%b/%0d/%0d ill=%b exc=%b alu=%b/%0d/%0d; need st=%0d req=%b we=%b ir=%b pc=%b/%0d reg=%b/%0d/%0d ill=%b exc=%b alu=%b/%0d/%0d",
                 t, $time, state, mem_req, mem_we, ir_we, pc_we, pc_sel, reg_we, reg_dst_sel, wb_sel,
                 illegal, exc, aluc, alu_a_sel, alu_b_sel, e.st, e.mreq, e.mwe, e.irwe, e.pcwe, e.pcs,
                 e.regwe, e.dst, e.wb, e.ill, e.exc, e.aluc, e.a, e.b);
      end
    end
  end

  task automatic rst_cycle(input logic [31:0] ins);
    cyc_t c;
    c = '0; c.rst = 1'b1; c.full = 1'b1; c.ins = ins;
    step(c);
  endtask

  task automatic issue(input int id, input int w1, input int w2, input bit z, input bit ov, input bit rst_mem);
    ent_t        t;
    cyc_t        c;
    logic [31:0] ins;
    logic [19:0] r20;
    logic [25:0] r26;
    t   = tab[id];
    r20 = 20'($urandom);
    r26 = 26'($urandom);
    ins = (t.op == 6'h00) ? {t.op, r20, t.fn} : {t.op, r26};
    cur_name = t.nm;
    for (int i = 0; i <= w1; i++) begin
      c = '0; c.ins = ins; c.mreq = 1'b1; c.b = 2'd1; c.alu = 1'b1;
      c.ack = (i == w1); c.irwe = c.ack; c.pcwe = c.ack;
      step(c);
    end
    c = '0; c.ins = ins; c.st = 3'd1; c.ack = 1'($urandom_range(0, 1));
    case (t.k)
      K_J:   begin c.pcwe = 1'b1; c.pcs = 2'd2; end
      K_JAL: begin c.pcwe = 1'b1; c.pcs = 2'd2; c.regwe = 1'b1; c.dst = 2'd2; c.wb = 2'd2; end
      K_JR:  begin c.pcwe = 1'b1; c.pcs = 2'd3; end
      K_ILL: c.ill = 1'b1;
      default: ;
    endcase
    step(c);
    if (t.k inside {K_J, K_JAL, K_JR, K_ILL}) return;
    c = '0; c.ins = ins; c.st = 3'd2; c.alu = 1'b1; c.aluc = t.aluc; c.a = t.a; c.b = t.b;
    c.z = z; c.ov = ov; c.ack = 1'($urandom_range(0, 1));
    c.pcwe = (t.k == K_BEQ && z) || (t.k == K_BNE && !z); c.pcs = 2'd1;
    step(c);
    if (t.k inside {K_BEQ, K_BNE}) return;
    if (TRAP_EN && t.trp && ov) begin
      repeat (3) begin
        c = '0; c.ins = ins; c.st = 3'd5; c.exc = 1'b1;
        c.ack = 1'($urandom_range(0, 1)); c.ov = 1'($urandom_range(0, 1));
        step(c);
      end
      rst_cycle(ins);
      return;
    end
    if (t.k inside {K_LW, K_SW}) begin
      for (int i = 0; i <= w2; i++) begin
        if (rst_mem && i == 1) begin
          rst_cycle(ins);
          rst_cycle(ins);
          return;
        end
        c = '0; c.ins = ins; c.st = 3'd3; c.mreq = 1'b1; c.mwe = (t.k == K_SW); c.ack = (i == w2);
        step(c);
      end
      if (t.k == K_SW) return;
    end
    c = '0; c.ins = ins; c.st = 3'd4; c.regwe = 1'b1; c.ack = 1'($urandom_range(0, 1));
    c.dst = (t.k == K_R) ? 2'd1 : 2'd0; c.wb = (t.k == K_LW) ? 2'd1 : 2'd0;
    step(c);
  endtask

  initial begin
    int wt;
    ent("sll",   K_R, 6'h00, 6'h00, 4'b1110, 2, 0, 0);
    ent("srl",   K_R, 6'h00, 6'h02, 4'b1101, 2, 0, 0);
    ent("sra",   K_R, 6'h00, 6'h03, 4'b1100, 2, 0, 0);
    ent("sllv",  K_R, 6'h00, 6'h04, 4'b1110, 1, 0, 0);
    ent("srlv",  K_R, 6'h00, 6'h06, 4'b1101, 1, 0, 0);
    ent("srav",  K_R, 6'h00, 6'h07, 4'b1100, 1, 0, 0);
    ent("add",   K_R, 6'h00, 6'h20, 4'b0010, 1, 0, 1);
    ent("addu",  K_R, 6'h00, 6'h21, 4'b0000, 1, 0, 0);
    ent("sub",   K_R, 6'h00, 6'h22, 4'b0011, 1, 0, 1);
    ent("subu",  K_R, 6'h00, 6'h23, 4'b0001, 1, 0, 0);
    ent("and",   K_R, 6'h00, 6'h24, 4'b0100, 1, 0, 0);
    ent("or",    K_R, 6'h00, 6'h25, 4'b0101, 1, 0, 0);
    ent("xor",   K_R, 6'h00, 6'h26, 4'b0110, 1, 0, 0);
    ent("nor",   K_R, 6'h00, 6'h27, 4'b0111, 1, 0, 0);
    ent("slt",   K_R, 6'h00, 6'h2A, 4'b1011, 1, 0, 0);
    ent("sltu",  K_R, 6'h00, 6'h2B, 4'b1010, 1, 0, 0);
    ent("jr",    K_JR, 6'h00, 6'h08, 4'b0000, 0, 0, 0);
    ent("addi",  K_I, 6'h08, 6'h00, 4'b0010, 1, 2, 1);
    ent("addiu", K_I, 6'h09, 6'h00, 4'b0000, 1, 2, 0);
    ent("slti",  K_I, 6'h0A, 6'h00, 4'b1011, 1, 2, 0);
    ent("sltiu", K_I, 6'h0B, 6'h00, 4'b1010, 1, 2, 0);
    ent("andi",  K_I, 6'h0C, 6'h00, 4'b0100, 1, 3, 0);
    ent("ori",   K_I, 6'h0D, 6'h00, 4'b0101, 1, 3, 0);
    ent("xori",  K_I, 6'h0E, 6'h00, 4'b0110, 1, 3, 0);
    ent("lui",   K_I, 6'h0F, 6'h00, 4'b1000, 1, 3, 0);
    ent("lw",    K_LW, 6'h23, 6'h00, 4'b0000, 1, 2, 0);
    ent("sw",    K_SW, 6'h2B, 6'h00, 4'b0000, 1, 2, 0);
    ent("beq",   K_BEQ, 6'h04, 6'h00, 4'b0001, 1, 0, 0);
    ent("bne",   K_BNE, 6'h05, 6'h00, 4'b0001, 1, 0, 0);
    ent("j",     K_J, 6'h02, 6'h00, 4'b0000, 0, 0, 0);
    ent("jal",   K_JAL, 6'h03, 6'h00, 4'b0000, 0, 0, 0);
    ent("ill3f", K_ILL, 6'h3F, 6'h00, 4'b0000, 0, 0, 0);
    ent("ill01", K_ILL, 6'h01, 6'h00, 4'b0000, 0, 0, 0);
    ent("illfn", K_ILL, 6'h00, 6'h3F, 4'b0000, 0, 0, 0);
    ent("ill20", K_ILL, 6'h20, 6'h00, 4'b0000, 0, 0, 0);
    repeat (3) rst_cycle(32'h0);
    #1;
    nchk++;
    if (state !== 3'd0 || mem_req !== 1'b0 || mem_we !== 1'b0 || ir_we !== 1'b0 || pc_we !== 1'b0 ||
        reg_we !== 1'b0 || illegal !== 1'b0 || exc !== 1'b0 || aluc !== 4'b0000 || alu_a_sel !== 2'd0 ||
        alu_b_sel !== 2'd0 || pc_sel !== 2'd0 || reg_dst_sel !== 2'd0 || wb_sel !== 2'd0) begin
      nerr++;
      $display("FAIL reset-state @%0t: st=%0d req=%b we=%b ir=%b pc=%b reg=%b ill=%b exc=%b aluc=%b sel=%0d/%0d/%0d/%0d/%0d",
               $time, state, mem_req, mem_we, ir_we, pc_we, reg_we, illegal, exc, aluc,
               alu_a_sel, alu_b_sel, pc_sel, reg_dst_sel, wb_sel);
    end
    issue(idx("addu"), 0, 0, 0, 0, 0);
    issue(idx("lw"),   0, 2, 0, 0, 0);
    issue(idx("beq"),  0, 0, 1, 0, 0);
    issue(idx("bne"),  0, 0, 1, 0, 0);
    issue(idx("sll"),  1, 0, 0, 0, 0);
    issue(idx("lui"),  0, 0, 0, 0, 0);
    issue(idx("sw"),   2, 1, 0, 0, 0);
    issue(idx("j"),    0, 0, 0, 0, 0);
    issue(idx("jal"),  1, 0, 0, 0, 0);
    issue(idx("jr"),   0, 0, 0, 0, 0);
    issue(idx("addi"), 0, 0, 0, 1, 0);
    issue(idx("ill3f"), 0, 0, 0, 0, 0);
    issue(idx("lw"),   0, 2, 0, 0, 1);
    for (int n = 0; n < 400; n++) begin
      int w2;
      w2 = $urandom_range(0, 2);
      issue($urandom_range(0, tab.size() - 1), $urandom_range(0, 2), w2,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            w2 >= 1 && $urandom_range(0, 15) == 0);
    end
    wt = 0;
    while (expq.size() > 0 && wt < 20) begin
      @(posedge clk);
      wt++;
    end
    nchk++;
    if (expq.size() != 0) begin
      nerr++;
      $display("FAIL expired-wait @%0t: %0d expected cycles never checked", $time, expq.size());
    end
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
